fir_axilite_cfg: RTL and testbench

//  AXI-Lite responder (slave) for the FIR core's configuration space; the other end of the bench's AXI-Lite initiator.

---
 rtl/fir_cfg_pkg.sv | 28 ++
 rtl/fir_cfg_rd_fsm.sv | 85 ++++++++
 rtl/fir_axilite_cfg.sv | 175 +++++++++++++++++
 tb/tb_fir_axilite_cfg.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_cfg_pkg.sv
// fir_cfg_pkg
//   Shared definitions for the FIR configuration slice: register byte
//   offsets, ap_ctrl bit positions, the read-channel state encoding and
//   a helper that decides whether a byte address falls on a tap word.
package fir_cfg_pkg;

    localparam logic [11:0] ADDR_AP_CTRL = 12'h00;
    localparam logic [11:0] ADDR_LEN     = 12'h10;
    localparam logic [11:0] ADDR_TAP0    = 12'h20;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    // True for word-aligned addresses inside 0x20 .. 0x20+4*(num_taps-1).
    function automatic logic is_tap_addr(input int unsigned addr, input int unsigned num_taps);
        return (addr >= 32'(ADDR_TAP0)) &&
               (addr <= 32'(ADDR_TAP0) + 32'(4 * (num_taps - 1))) &&
               (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fir_cfg_rd_fsm.sv
// fir_cfg_rd_fsm
//   AXI-Lite read channel: IDLE -> ADDR (arready for one cycle, address
//   latched, tap BRAM read issued by the parent) -> DATA (rvalid held until
//   rready). The parent supplies the register word and says whether the
//   word must instead come from the BRAM output, which only becomes valid
//   in the first DATA cycle.
// Ports
//   axis_clk, axis_rst      clock, async active-high reset
//   arvalid, araddr         read address request
//   rd_allow                parent permits accepting a new read this cycle
//   rready                  read data accepted by the initiator
//   rd_word                 register value for rd_addr (valid in ADDR)
//   rd_use_tap              rd_addr targets a live tap BRAM word
//   tap_Do                  tap BRAM read data (1-cycle latency)
//   arready, rvalid, rdata  AXI-Lite read outputs
//   rd_addr                 latched read address
//   rd_addr_phase           high while in ADDR
module fir_cfg_rd_fsm
    import fir_cfg_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rd_allow,
    input  logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rd_word,
    input  logic                   rd_use_tap,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   arready,
    output logic                   rvalid,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [pADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_addr_phase
);

    rd_state_t              state;
    logic [pDATA_WIDTH-1:0] rdata_q;
    logic                   live_tap;

    // The BRAM word is passed straight through in the first DATA cycle and
    // captured there, so rdata stays stable even if the BRAM port is later
    // reused by a write or handed to the engine.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state    <= R_IDLE;
            rd_addr  <= '0;
            rdata_q  <= '0;
            live_tap <= 1'b0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (arvalid && rd_allow) begin
                        rd_addr <= araddr;
                        state   <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    rdata_q  <= rd_word;
                    live_tap <= rd_use_tap;
                    state    <= R_DATA;
                end
                R_DATA: begin
                    if (live_tap) begin
                        rdata_q  <= tap_Do;
                        live_tap <= 1'b0;
                    end
                    if (rready) begin
                        state <= R_IDLE;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

    assign arready       = (state == R_ADDR);
    assign rd_addr_phase = (state == R_ADDR);
    assign rvalid        = (state == R_DATA);
    assign rdata         = !rvalid ? '0 : (live_tap ? tap_Do : rdata_q);

endmodule

// File: rtl/fir_axilite_cfg.sv
// fir_axilite_cfg
//   AXI-Lite configuration responder for the FIR core. Decodes ap_ctrl
//   (0x00), data_length (0x10) and the tap window (0x20 ..), owns the tap
//   BRAM port while idle and hands it to the engine while running.
// Ports
//   axis_clk, axis_rst            clock, async active-high reset
//   aw*/w*                        write address/data handshake (no B channel)
//   ar*/r*                        read address/data handshake
//   tap_WE/EN/Di/A, tap_Do        tap BRAM port (A is offset from 0x20)
//   eng_tap_A                     engine tap address, used while busy
//   eng_done                      engine finished pulse
//   ap_start_o                    one-cycle start pulse to engine
//   data_length                   programmed sample count
// Build option
//   FIR_TAP_LOCK_EN: busy-time tap/length writes are acked and discarded
//   and tap reads return all ones; otherwise tap accesses stall until idle.
module fir_axilite_cfg
    import fir_cfg_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    input  logic                   eng_done,
    output logic                   ap_start_o,
    output logic [pDATA_WIDTH-1:0] data_length
);

`ifdef FIR_TAP_LOCK_EN
    localparam bit TAP_LOCK = 1'b1;
`else
    localparam bit TAP_LOCK = 1'b0;
`endif

    logic                   ap_start;
    logic                   ap_done;
    logic                   ap_idle;
    logic                   aw_is_tap;
    logic                   wr_stall;
    logic                   wr_go;
    logic                   wr_fire;
    logic                   rd_allow;
    logic [pDATA_WIDTH-1:0] rd_word;
    logic                   rd_use_tap;
    logic [pADDR_WIDTH-1:0] rd_addr;
    logic                   rd_addr_phase;
    logic                   rd_ctrl_done;

    assign aw_is_tap = is_tap_addr(32'(awaddr), Tape_Num);
    // Without the lock, a busy-time tap write simply waits for the engine.
    assign wr_stall  = !TAP_LOCK && !ap_idle && aw_is_tap;
    assign wr_go     = awvalid && wvalid && !awready && !wr_stall;
    assign wr_fire   = awready && awvalid && wvalid;
    assign wready    = awready;

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            awready <= 1'b0;
        end else begin
            awready <= wr_go;
        end
    end

    // ap_done clear is written before the set so a coincident eng_done wins.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            ap_start    <= 1'b0;
            ap_done     <= 1'b0;
            ap_idle     <= 1'b1;
            data_length <= '0;
        end else begin
            ap_start <= 1'b0;
            if (wr_fire && awaddr == pADDR_WIDTH'(ADDR_AP_CTRL) && wdata[AP_START_BIT] && ap_idle) begin
                ap_start <= 1'b1;
                ap_idle  <= 1'b0;
            end
            if (wr_fire && awaddr == pADDR_WIDTH'(ADDR_LEN) && (!TAP_LOCK || ap_idle)) begin
                data_length <= wdata;
            end
            if (rd_ctrl_done) begin
                ap_done <= 1'b0;
            end
            if (eng_done) begin
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
            end
        end
    end

    assign ap_start_o = ap_start;

    // A pending write blocks read acceptance so the two never share the
    // BRAM port in the same cycle.
    assign rd_allow = !(awvalid && wvalid) &&
                      !(!TAP_LOCK && !ap_idle && is_tap_addr(32'(araddr), Tape_Num));

    assign rd_ctrl_done = rvalid && rready && (rd_addr == pADDR_WIDTH'(ADDR_AP_CTRL));

    always_comb begin
        rd_word    = '0;
        rd_use_tap = 1'b0;
        if (rd_addr == pADDR_WIDTH'(ADDR_AP_CTRL)) begin
            rd_word[AP_START_BIT] = ap_start;
            rd_word[AP_DONE_BIT]  = ap_done;
            rd_word[AP_IDLE_BIT]  = ap_idle;
        end else if (rd_addr == pADDR_WIDTH'(ADDR_LEN)) begin
            rd_word = data_length;
        end else if (is_tap_addr(32'(rd_addr), Tape_Num)) begin
            if (!ap_idle) begin
                rd_word = '1;
            end else begin
                rd_use_tap = 1'b1;
            end
        end
    end

    always_comb begin
        tap_WE = 4'h0;
        tap_EN = 1'b0;
        tap_Di = wdata;
        tap_A  = '0;
        if (!ap_idle) begin
            tap_A  = eng_tap_A;
            tap_EN = 1'b1;
        end else if (wr_fire && aw_is_tap) begin
            tap_A  = awaddr - pADDR_WIDTH'(ADDR_TAP0);
            tap_EN = 1'b1;
            tap_WE = 4'hf;
        end else if (rd_addr_phase && rd_use_tap) begin
            tap_A  = rd_addr - pADDR_WIDTH'(ADDR_TAP0);
            tap_EN = 1'b1;
        end
    end

    fir_cfg_rd_fsm #(
        .pADDR_WIDTH(pADDR_WIDTH),
        .pDATA_WIDTH(pDATA_WIDTH)
    ) u_rd_fsm (
        .axis_clk     (axis_clk),
        .axis_rst     (axis_rst),
        .arvalid      (arvalid),
        .araddr       (araddr),
        .rd_allow     (rd_allow),
        .rready       (rready),
        .rd_word      (rd_word),
        .rd_use_tap   (rd_use_tap),
        .tap_Do       (tap_Do),
        .arready      (arready),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .rd_addr      (rd_addr),
        .rd_addr_phase(rd_addr_phase)
    );

endmodule

// File: tb/tb_fir_axilite_cfg.sv
// tb_fir_axilite_cfg
//   Directed bench for fir_axilite_cfg with a behavioural tap BRAM
//   (1-cycle read latency) and a hand-driven engine (eng_tap_A, eng_done).
module tb_fir_axilite_cfg;

    logic        axis_clk = 1'b0;
    logic        axis_rst = 1'b1;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [11:0] awaddr = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] wdata = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [11:0] araddr = '0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] rdata;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [31:0] tap_Di;
    logic [11:0] tap_A;
    logic [31:0] tap_Do = '0;
    logic [11:0] eng_tap_A = 12'h014;
    logic        eng_done = 1'b0;
    logic        ap_start_o;
    logic [31:0] data_length;

    int checks = 0;
    int errors = 0;

    always #5 axis_clk = ~axis_clk;

    fir_axilite_cfg dut (
        .axis_clk   (axis_clk),
        .axis_rst   (axis_rst),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .tap_WE     (tap_WE),
        .tap_EN     (tap_EN),
        .tap_Di     (tap_Di),
        .tap_A      (tap_A),
        .tap_Do     (tap_Do),
        .eng_tap_A  (eng_tap_A),
        .eng_done   (eng_done),
        .ap_start_o (ap_start_o),
        .data_length(data_length)
    );

    // Tap BRAM model: 11 words, read-before-write, 1-cycle read latency.
    logic [31:0] tap_mem [0:10];
    wire  [9:0]  tap_idx = tap_A[11:2];

    initial begin
        for (int i = 0; i < 11; i++) tap_mem[i] = '0;
    end

    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_idx < 10'd11) begin
                tap_Do <= tap_mem[tap_idx];
                if (tap_WE == 4'hf) tap_mem[tap_idx] <= tap_Di;
            end else begin
                tap_Do <= '0;
            end
        end
    end

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs [15];
    int   coef [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    logic [31:0] rd_val;
    int          rd_lat;
    int          t_aw, t_ar, t_r;
    logic        saw_ready;
    logic        got;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic axiWrite(input logic [11:0] addr, input logic [31:0] data);
        logic done;
        done = 1'b0;
        @(posedge axis_clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge axis_clk);
            if (awready) begin
                if (!wready) checkOutput("wready_with_awready", {31'b0, wready}, 32'd1);
                @(posedge axis_clk); #1;
                done = 1'b1;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!done) checkOutput("aw_timeout", 32'd0, 32'd1);
    endtask

    task automatic axiRead(input logic [11:0] addr, output logic [31:0] data, output int lat);
        logic done;
        done = 1'b0;
        data = 'x;
        lat  = -1;
        @(posedge axis_clk); #1;
        arvalid = 1'b1; araddr = addr; rready = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge axis_clk);
            if (rvalid) begin
                data = rdata;
                lat  = n;
                done = 1'b1;
                @(posedge axis_clk); #1;
            end else if (arready) begin
                @(posedge axis_clk); #1;
                arvalid = 1'b0;
            end
        end
        arvalid = 1'b0;
        if (!done) checkOutput("rd_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        axiWrite(v.addr, v.wdata);
    endtask

    task automatic pulseDone();
        @(posedge axis_clk); #1; eng_done = 1'b1;
        @(posedge axis_clk); #1; eng_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{12'h010, 32'd600, 32'd600};
        for (int k = 0; k < 11; k++)
            vecs[1+k] = '{12'(32'h20 + 4*k), 32'(coef[k]), 32'(coef[k])};
        vecs[12] = '{12'h00C, 32'h0000_1234, 32'h0};
        vecs[13] = '{12'h022, 32'h0000_0055, 32'h0};
        vecs[14] = '{12'h04C, 32'h0000_0007, 32'h0};

        // 1. reset state and idle readback
        repeat (3) @(posedge axis_clk);
        #1 axis_rst = 1'b0;
        repeat (2) @(negedge axis_clk);
        checkOutput("rst_awready", {31'b0, awready}, 32'd0);
        checkOutput("rst_arready", {31'b0, arready}, 32'd0);
        checkOutput("rst_rvalid", {31'b0, rvalid}, 32'd0);
        checkOutput("rst_tap_EN", {31'b0, tap_EN}, 32'd0);
        checkOutput("rst_data_length", data_length, 32'd0);
        axiRead(12'h000, rd_val, rd_lat);
        checkOutput("idle_ap_ctrl", rd_val, 32'h4);

        // 2. table of register / tap writes, then readback
        for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);
        checkOutput("data_length_port", data_length, 32'd600);
        for (int i = 0; i < 15; i++) begin
            axiRead(vecs[i].addr, rd_val, rd_lat);
            checkOutput($sformatf("vec%0d_data", i), rd_val, vecs[i].expected);
            checkOutput($sformatf("vec%0d_latency", i), 32'(rd_lat), 32'd2);
        end

        // 3. start, busy status, done and read-to-clear
        axiWrite(12'h000, 32'h1);
        checkOutput("ap_start_o_high", {31'b0, ap_start_o}, 32'd1);
        @(posedge axis_clk); #1;
        checkOutput("ap_start_o_low", {31'b0, ap_start_o}, 32'd0);
        checkOutput("busy_tap_A", {20'b0, tap_A}, 32'h014);
        checkOutput("busy_tap_EN", {31'b0, tap_EN}, 32'd1);
        checkOutput("busy_tap_WE", {28'b0, tap_WE}, 32'd0);
        axiRead(12'h000, rd_val, rd_lat);
        checkOutput("busy_ap_ctrl", rd_val, 32'h0);
        axiWrite(12'h000, 32'h1);
        checkOutput("restart_ignored", {31'b0, ap_start_o}, 32'd0);
        pulseDone();
        axiRead(12'h000, rd_val, rd_lat);
        checkOutput("done_ap_ctrl", rd_val, 32'h6);
        axiRead(12'h000, rd_val, rd_lat);
        checkOutput("cleared_ap_ctrl", rd_val, 32'h4);

        // 4. tap write while busy
        axiWrite(12'h000, 32'h1);
`ifdef FIR_TAP_LOCK_EN
        axiWrite(12'h024, 32'd99);
        axiWrite(12'h010, 32'd5);
        checkOutput("locked_len", data_length, 32'd600);
        axiRead(12'h024, rd_val, rd_lat);
        checkOutput("locked_tap_read", rd_val, 32'hffff_ffff);
        pulseDone();
        axiRead(12'h024, rd_val, rd_lat);
        checkOutput("locked_tap_kept", rd_val, 32'hffff_fff6);
`else
        @(posedge axis_clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h024; wdata = 32'd99;
        saw_ready = 1'b0;
        repeat (8) begin
            @(negedge axis_clk);
            if (awready) saw_ready = 1'b1;
        end
        checkOutput("stall_awready", {31'b0, saw_ready}, 32'd0);
        pulseDone();
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge axis_clk);
            if (awready) begin
                got = 1'b1;
                @(posedge axis_clk); #1;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        checkOutput("stall_released", {31'b0, got}, 32'd1);
        axiRead(12'h024, rd_val, rd_lat);
        checkOutput("stalled_tap_written", rd_val, 32'd99);
`endif
        axiRead(12'h000, rd_val, rd_lat);
        checkOutput("done_after_busy", rd_val, 32'h6);

        // 5. simultaneous write and read to 0x28
        @(posedge axis_clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h028; wdata = 32'd77;
        arvalid = 1'b1; araddr = 12'h028; rready = 1'b1;
        t_aw = -1; t_ar = -1; t_r = -1; rd_val = '0;
        for (int n = 0; n < 40 && t_r < 0; n++) begin
            @(negedge axis_clk);
            if (rvalid) begin
                t_r = n; rd_val = rdata;
            end
            if (awready && t_aw < 0) t_aw = n;
            if (arready && t_ar < 0) t_ar = n;
            if (awready || arready) begin
                @(posedge axis_clk); #1;
                if (awready === 1'b0 && t_aw >= 0) begin
                    awvalid = 1'b0; wvalid = 1'b0;
                end
                if (t_ar >= 0) arvalid = 1'b0;
            end
        end
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checkOutput("same_cycle_aw_seen", {31'b0, t_aw >= 0}, 32'd1);
        checkOutput("same_cycle_write_first", {31'b0, t_ar > t_aw}, 32'd1);
        checkOutput("same_cycle_read_data", rd_val, 32'd77);

        // 6. reset while holding read data
        axiWrite(12'h000, 32'h1);
        @(posedge axis_clk); #1;
        arvalid = 1'b1; araddr = 12'h010; rready = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge axis_clk);
            if (rvalid) got = 1'b1;
            else if (arready) begin
                @(posedge axis_clk); #1;
                arvalid = 1'b0;
            end
        end
        arvalid = 1'b0;
        checkOutput("pre_reset_rvalid", {31'b0, got}, 32'd1);
        #1 axis_rst = 1'b1;
        #1;
        checkOutput("async_rvalid_drop", {31'b0, rvalid}, 32'd0);
        checkOutput("async_rdata_zero", rdata, 32'd0);
        checkOutput("async_len_zero", data_length, 32'd0);
        checkOutput("async_tap_EN_idle", {31'b0, tap_EN}, 32'd0);
        @(negedge axis_clk);
        axis_rst = 1'b0; rready = 1'b1;
        axiRead(12'h000, rd_val, rd_lat);
        checkOutput("post_reset_ap_ctrl", rd_val, 32'h4);
        axiRead(12'h010, rd_val, rd_lat);
        checkOutput("post_reset_len", rd_val, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
